// File: rtl/score_bcd_scanner.sv
// Binary score to BCD converter (serial double-dabble) driving a 4-digit
// multiplexed seven-segment display with optional leading-zero blanking.
module score_bcd_scanner #(
  parameter int SCAN_BITS = 16,
  parameter bit LZ_BLANK  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] score_in,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [3:0]  digit_out,
  output logic [3:0]  ssd_ctl
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             iter_q, iter_d;
  logic [13:0]            bin_q, bin_d;
  logic [15:0]            bcd_q, bcd_d;
  logic [15:0]            disp_q, disp_d;
  logic                   done_q, done_d;
  logic [SCAN_BITS-1:0]   scan_q, scan_d;
  logic [3:0]             digit_q, digit_d;
  logic [3:0]             ctl_q, ctl_d;
  logic [15:0]            adj_s;
  logic [1:0]             sel_s;
  logic [13:0]            sat_s;

  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = b[4*i +: 4];
      end
    end
    return r;
  endfunction

  assign adj_s = add3(bcd_q);
  assign sat_s = (score_in > 14'd9999) ? 14'd9999 : score_in;
  assign sel_s = scan_q[SCAN_BITS-1 -: 2];

  // Conversion FSM and display-register update
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    disp_d  = disp_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          bin_d   = sat_s;
          bcd_d   = 16'd0;
          iter_d  = 4'd0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {adj_s[14:0], bin_q, 1'b0};
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd13) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        disp_d  = bcd_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Digit select and blanking; a nibble blanks when it and all higher nibbles are zero
  always_comb begin
    scan_d  = scan_q + {{(SCAN_BITS-1){1'b0}}, 1'b1};
    digit_d = disp_q[3:0];
    ctl_d   = 4'b1110;
    case (sel_s)
      2'd0: begin
        ctl_d   = 4'b1110;
        digit_d = disp_q[3:0];
      end
      2'd1: begin
        ctl_d   = 4'b1101;
        digit_d = (LZ_BLANK && (disp_q[15:4] == 12'd0)) ? 4'hF : disp_q[7:4];
      end
      2'd2: begin
        ctl_d   = 4'b1011;
        digit_d = (LZ_BLANK && (disp_q[15:8] == 8'd0)) ? 4'hF : disp_q[11:8];
      end
      3'd3: begin
        ctl_d   = 4'b0111;
        digit_d = (LZ_BLANK && (disp_q[15:12] == 4'd0)) ? 4'hF : disp_q[15:12];
      end
      default: begin
        ctl_d   = 4'b1110;
        digit_d = disp_q[3:0];
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      iter_q  <= 4'd0;
      bin_q   <= 14'd0;
      bcd_q   <= 16'd0;
      disp_q  <= 16'd0;
      done_q  <= 1'b0;
      scan_q  <= '0;
      digit_q <= 4'd0;
      ctl_q   <= 4'b1110;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      disp_q  <= disp_d;
      done_q  <= done_d;
      scan_q  <= scan_d;
      digit_q <= digit_d;
      ctl_q   <= ctl_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign digit_out = digit_q;
  assign ssd_ctl   = ctl_q;

endmodule

// File: doc/score_bcd_scanner.md
SCORE_BCD_SCANNER -- requirements
Module: score_bcd_scanner

Interface
REQ-001 Parameter SCAN_BITS, default 16: width of the free-running refresh counter; the digit select is its top 2 bits.
REQ-002 Parameter LZ_BLANK, default 1: 1 enables leading-zero blanking, 0 disables it.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 score_in  input  14  unsigned binary score, sampled only when a load is accepted.
REQ-006 load  input  1  conversion request, single-cycle strobe.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse when the display registers are updated.
REQ-009 digit_out  output  4  BCD value of the currently scanned digit; 4'hF means blank; feeds the 7-segment decoder.
REQ-010 ssd_ctl  output  4  active-low digit enable, exactly one bit low; bit0 is ones, bit3 is thousands.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT and DONE; busy SHALL be high exactly when the state is not IDLE.
REQ-012 load SHALL be accepted only in IDLE; a load in SHIFT or DONE is ignored and not queued.
REQ-013 On acceptance, score_in SHALL be captured with saturation: values above 9999 (up to 16383) become 9999.
REQ-014 On acceptance, the 16-bit BCD working register and the 4-bit iteration counter SHALL be cleared, and the state goes to SHIFT.
REQ-015 Each SHIFT cycle SHALL perform one double-dabble iteration: add 3 to every BCD nibble >= 5, then shift {bcd,bin} left by 1.
REQ-016 SHIFT SHALL last exactly 14 cycles; after the 14th iteration the state goes to DONE.
REQ-017 On the DONE-to-IDLE edge, the working register SHALL be copied into the 4-nibble display register and done registered high for exactly one cycle.
REQ-018 Latency SHALL be fixed: load accepted at edge E; display updated at edge E+15; done high during the cycle following E+15.
REQ-019 A load asserted while done is high SHALL be accepted, since the state is IDLE.
REQ-020 The display register SHALL hold its value between conversions; a conversion in progress never alters the displayed digits.
REQ-021 The refresh counter SHALL increment every cycle and wrap from 2^SCAN_BITS-1 to 0.
REQ-022 The digit select sel SHALL be counter[SCAN_BITS-1:SCAN_BITS-2], mapped as follows:
- 0: ssd_ctl=1110, ones
- 1: ssd_ctl=1101, tens
- 2: ssd_ctl=1011, hundreds
- 3: ssd_ctl=0111, thousands
REQ-023 digit_out and ssd_ctl SHALL be registered and change on the same edge, so no cycle pairs a digit value with the wrong enable.
REQ-024 With LZ_BLANK=1, a thousands/hundreds/tens nibble SHALL output 4'hF when it and every higher nibble are zero; the ones digit is never blanked.
REQ-025 With LZ_BLANK=0, digit_out SHALL always equal the display nibble.
REQ-026 Scanning SHALL continue uninterrupted during conversions.

Reset
REQ-027 While rst is high at a clock edge, all of the following SHALL be forced:
- state IDLE; busy 0; done 0
- iteration counter, refresh counter, working and display registers all 0
- ssd_ctl=1110; digit_out=0
REQ-028 Reset during SHIFT or DONE SHALL abort the conversion: no done pulse, display reads 0.
REQ-029 rst SHALL have priority over load in the same cycle.

Verification (bench uses SCAN_BITS=4)
REQ-030 Reset: hold rst 2 cycles -> ssd_ctl=1110, digit_out=0, busy=0, done=0, and with LZ_BLANK=1 the tens/hundreds/thousands slots show F.
REQ-031 Load score 1234 -> busy high 15 cycles, done pulse at E+15, then the scan shows 4/1110, 3/1101, 2/1011, 1/0111.
REQ-032 Saturation and zero handling: score 12000 -> 9,9,9,9; score 9999 -> 9,9,9,9; score 1000 -> 0,0,0,1 (internal zeros shown).
REQ-033 Blanking: score 7 -> 7,F,F,F with LZ_BLANK=1; score 7 -> 7,0,0,0 with LZ_BLANK=0; score 0 -> 0,F,F,F.
REQ-034 Load with score 55 during the 5th SHIFT cycle of a 1234 conversion -> ignored, result 1234; load 55 in the done cycle -> accepted, result 55 at +15.
REQ-035 Reset after the 7th SHIFT iteration of 4321 -> no done pulse, display 0, busy 0 on the next cycle.
